// File: rtl/clk_en_gen.sv
// clk_en_gen: one-cycle tick every DIV clocks from an N-bit wrap counter; clk/rst_n in, tick out
module clk_en_gen #(
  parameter int DIV = 2,
  parameter int N   = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  logic [N-1:0] cnt;
  assign tick = cnt == N'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_top.sv
// fifo_top: strobe-paced FIFO; in clk_i, rst_i(async low), dat_i, push0(write), push1(read); out dat_o, empty, full
module fifo_top #(
  parameter int DW          = 4,
  parameter int AW          = 2,
  parameter int CLKIN       = 50,
  parameter int wclk_CLKOUT = 25,
  parameter int rclk_CLKOUT = 10,
  parameter int w_n         = 18,
  parameter int r_n         = 17
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] dat_i,
  input  logic          push0,
  input  logic          push1,
  output logic [DW-1:0] dat_o,
  output logic          empty,
  output logic          full
);
  localparam int WDIV = CLKIN / wclk_CLKOUT;
  localparam int RDIV = CLKIN / rclk_CLKOUT;
  logic          wr_tick, rd_tick, wr_en, rd_en;
  logic [AW:0]   wptr, rptr;
  logic [DW-1:0] mem [2**AW];
  clk_en_gen #(.DIV(WDIV), .N(w_n)) u_wr_en (.clk(clk_i), .rst_n(rst_i), .tick(wr_tick));
  clk_en_gen #(.DIV(RDIV), .N(r_n)) u_rd_en (.clk(clk_i), .rst_n(rst_i), .tick(rd_tick));
  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr_en = wr_tick & push0 & ~full;
  assign rd_en = rd_tick & push1 & ~empty;
  always_ff @(posedge clk_i)
    if (wr_en) mem[wptr[AW-1:0]] <= dat_i;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      dat_o <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) begin
        rptr  <= rptr + 1'b1;
        dat_o <= mem[rptr[AW-1:0]];
      end
    end
endmodule

// File: tb/tb_fifo_top.sv
// tb_fifo_top: directed table plus sequences for fifo_top, default build and a WDIV=RDIV=1 build
module tb_fifo_top;
  typedef struct {
    int n;
    int p0;
    int p1;
    int d;
    int em;
    int fu;
    int dq;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, q0, q1;
  logic a0 = 1'b0, b0 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic e0, f0, e1, f1;
  int total = 0, bad = 0, e = 0;
  logic [3:0] q[$];
  logic [3:0] xd = '0;
  logic [3:0] val = '0;
  vec_t tv[14];
  always #5 clk = ~clk;
  fifo_top u0 (.clk_i(clk), .rst_i(rst_n), .dat_i(d0), .push0(a0), .push1(b0),
               .dat_o(q0), .empty(e0), .full(f0));
  fifo_top #(.CLKIN(10), .wclk_CLKOUT(10), .rclk_CLKOUT(10), .w_n(1), .r_n(1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .dat_i(d1), .push0(a1), .push1(b1),
    .dat_o(q1), .empty(e1), .full(f1));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", n, act, exp, $time);
    end
  endtask
  task automatic mstep(input logic p0, input logic p1, input logic [3:0] d);
    bit wf, re;
    a0 = p0;
    b0 = p1;
    d0 = d;
    @(posedge clk);
    #1;
    wf = q.size() == 4;
    re = q.size() == 0;
    if (e % 5 == 4 && p1 && !re) xd = q.pop_front();
    if (e % 2 == 1 && p0 && !wf) q.push_back(d);
    e++;
    chk("dout", 32'(q0), 32'(xd));
    chk("empty", 32'(e0), 32'(q.size() == 0));
    chk("full", 32'(f0), 32'(q.size() == 4));
  endtask
  initial begin
    tv[0]  = '{1, 1, 0, 0, 1, 0, 0};
    tv[1]  = '{1, 1, 0, 1, 0, 0, 0};
    tv[2]  = '{2, 1, 0, 2, 0, 0, 0};
    tv[3]  = '{2, 1, 0, 3, 0, 0, 0};
    tv[4]  = '{1, 1, 0, 4, 0, 0, 0};
    tv[5]  = '{1, 1, 0, 4, 0, 1, 0};
    tv[6]  = '{3, 1, 0, 5, 0, 1, 0};
    tv[7]  = '{3, 0, 1, 9, 0, 1, 0};
    tv[8]  = '{1, 0, 1, 9, 0, 0, 1};
    tv[9]  = '{4, 0, 1, 9, 0, 0, 1};
    tv[10] = '{5, 0, 1, 9, 0, 0, 2};
    tv[11] = '{5, 0, 1, 9, 0, 0, 3};
    tv[12] = '{5, 0, 1, 9, 1, 0, 4};
    tv[13] = '{2, 0, 1, 9, 1, 0, 4};
    a0 = 1'b1;
    b0 = 1'b1;
    repeat (20) begin
      d0 = 4'($urandom_range(15, 0));
      @(negedge clk);
      chk("rst_empty", 32'(e0), 32'd1);
      chk("rst_full", 32'(f0), 32'd0);
      chk("rst_dout", 32'(q0), 32'd0);
      chk("rst_empty1", 32'(e1), 32'd1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++)
      for (int k = 0; k < tv[i].n; k++) begin
        a0 = tv[i].p0 != 0;
        b0 = tv[i].p1 != 0;
        d0 = 4'(tv[i].d);
        @(posedge clk);
        #1;
        e++;
        chk($sformatf("vec%0d_empty", i), 32'(e0), 32'(tv[i].em));
        chk($sformatf("vec%0d_full", i), 32'(f0), 32'(tv[i].fu));
        chk($sformatf("vec%0d_dout", i), 32'(q0), 32'(tv[i].dq));
      end
    xd = 4'd4;
    for (int i = 0; i < 70; i++) begin
      val = (val == 4'd15) ? 4'd1 : val + 4'd1;
      mstep(q.size() < 3, 1'b1, val);
    end
    for (int i = 0; i < 50 && q.size() != 2; i++) begin
      val = (val == 4'd15) ? 4'd1 : val + 4'd1;
      mstep(q.size() < 2, q.size() > 2, val);
    end
    chk("pre_rst_count", 32'(q.size()), 32'd2);
    a0 = 1'b0;
    b0 = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(e0), 32'd1);
    chk("arst_full", 32'(f0), 32'd0);
    chk("arst_dout", 32'(q0), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_empty", 32'(e0), 32'd1);
    chk("arst_hold_dout", 32'(q0), 32'd0);
    rst_n = 1'b1;
    e = 0;
    q.delete();
    xd = '0;
    repeat (8) mstep(1'b0, 1'b1, 4'd6);
    a1 = 1'b1;
    b1 = 1'b0;
    d1 = 4'd7;
    @(posedge clk);
    #1;
    chk("u1_first_empty", 32'(e1), 32'd0);
    chk("u1_first_dout", 32'(q1), 32'd0);
    b1 = 1'b1;
    val = 4'd7;
    for (int k = 0; k < 6; k++) begin
      d1 = 4'(k + 9);
      @(posedge clk);
      #1;
      chk("u1_dout", 32'(q1), 32'(val));
      chk("u1_empty", 32'(e1), 32'd0);
      chk("u1_full", 32'(f1), 32'd0);
      val = d1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
